// File: rtl/cpu_trace_buffer.sv
// Instruction-retire trace buffer: classifies each retiring instruction, queues
// {class, PC, write data} in a first-word-fall-through FIFO and keeps retire statistics.
`timescale 1ns/1ps
module cpu_trace_buffer #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic                     trace_valid,
  input  logic [PC_W-1:0]          trace_pc,
  input  logic [31:0]              trace_instr,
  input  logic [DATA_W-1:0]        trace_wd,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [3:0]               rd_class,
  output logic [PC_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]        rd_wd,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         ovw_cnt,
  input  logic [3:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_val,
  input  logic                     clr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NUM_CLASSES = 9;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [3:0]        class_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [DATA_W-1:0] wd_mem    [DEPTH];

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q;
  logic [CNT_W-1:0]  class_cnt [NUM_CLASSES];

  logic [5:0] opcode, funct;
  logic [3:0] trace_class;
  logic       unused_instr_bits;
  logic       push, pop, full, wr_en, overwrite, drop, rd_adv;

  assign opcode            = trace_instr[31:26];
  assign funct             = trace_instr[5:0];
  assign unused_instr_bits = ^trace_instr[25:6];

  always_comb begin
    trace_class = 4'd0;
    case (opcode)
      6'd0: begin
        case (funct)
          6'd32:   trace_class = 4'd1;
          6'd34:   trace_class = 4'd2;
          6'd36:   trace_class = 4'd3;
          6'd37:   trace_class = 4'd4;
          default: trace_class = 4'd0;
        endcase
      end
      6'd35:   trace_class = 4'd5;
      6'd43:   trace_class = 4'd6;
      6'd4:    trace_class = 4'd7;
      6'd2:    trace_class = 4'd8;
      default: trace_class = 4'd0;
    endcase
  end

  // When full, the write slot coincides with the head, so a simultaneous pop
  // or an overwrite both retire the head while the new entry lands there.
  assign full      = (level_q == FULL_LEVEL);
  assign rd_valid  = (level_q != '0);
  assign push      = en & trace_valid;
  assign pop       = rd_valid & rd_ready;
  assign overwrite = push & full & ~pop & mode;
  assign drop      = push & full & ~pop & ~mode;
  assign wr_en     = push & (~full | pop | mode);
  assign rd_adv    = pop | overwrite;

  assign rd_class = class_mem[rd_ptr];
  assign rd_pc    = pc_mem[rd_ptr];
  assign rd_wd    = wd_mem[rd_ptr];
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      class_mem[wr_ptr] <= trace_class;
      pc_mem[wr_ptr]    <= trace_pc;
      wd_mem[wr_ptr]    <= trace_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_adv})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Statistics saturate; a clear in the same cycle as an event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      ovw_cnt  <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) class_cnt[i] <= '0;
    end else if (clr_cnt) begin
      drop_cnt <= '0;
      ovw_cnt  <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) class_cnt[i] <= '0;
    end else begin
      if (drop && drop_cnt != '1)     drop_cnt <= drop_cnt + 1'b1;
      if (overwrite && ovw_cnt != '1) ovw_cnt  <= ovw_cnt + 1'b1;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (push && trace_class == 4'(i) && class_cnt[i] != '1)
          class_cnt[i] <= class_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt_sel == 4'(i)) cnt_val = class_cnt[i];
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_cpu_trace_buffer;

  localparam int PC_W = 32, DATA_W = 32, DEPTH = 16, CNT_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic en = 0, mode = 0, trace_valid = 0, rd_ready = 0, clr_cnt = 0;
  logic [PC_W-1:0] trace_pc = '0;
  logic [31:0] trace_instr = '0;
  logic [DATA_W-1:0] trace_wd = '0;
  logic [3:0] cnt_sel = '0;
  logic rd_valid;
  logic [3:0] rd_class;
  logic [PC_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_wd;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] drop_cnt, ovw_cnt, cnt_val;

  cpu_trace_buffer #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_wd(trace_wd),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_class(rd_class), .rd_pc(rd_pc),
    .rd_wd(rd_wd), .level(level), .drop_cnt(drop_cnt), .ovw_cnt(ovw_cnt),
    .cnt_sel(cnt_sel), .cnt_val(cnt_val), .clr_cnt(clr_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cls;
    logic [31:0] pc;
    logic [31:0] wd;
  } entry_t;

  entry_t mq[$];
  int mcnt[9];
  int mdrop = 0, movw = 0;
  int checks = 0, passes = 0, fails = 0;

  function automatic int classOf(logic [31:0] w);
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    if (op == 0) begin
      if (fn == 32) return 1;
      if (fn == 34) return 2;
      if (fn == 36) return 3;
      if (fn == 37) return 4;
      return 0;
    end
    if (op == 35) return 5;
    if (op == 43) return 6;
    if (op == 4)  return 7;
    if (op == 2)  return 8;
    return 0;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w = $urandom;
    logic [5:0] f;
    case ($urandom_range(0, 4))
      0: f = 6'd32;
      1: f = 6'd34;
      2: f = 6'd36;
      3: f = 6'd37;
      default: f = 6'($urandom);
    endcase
    case ($urandom_range(0, 7))
      0, 1: begin w[31:26] = 6'd0; w[5:0] = f; end
      2: w[31:26] = 6'd35;
      3: w[31:26] = 6'd43;
      4: w[31:26] = 6'd4;
      5: w[31:26] = 6'd2;
      6: w[31:26] = 6'd8;
      default: w[31:26] = 6'($urandom);
    endcase
    return w;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < 9; i++) mcnt[i] = 0;
    mdrop = 0;
    movw = 0;
  endtask

  task automatic modelStep(input logic s_en, s_mode, s_valid, input logic [31:0] s_pc,
                           s_instr, s_wd, input logic s_ready, s_clr);
    bit push = s_en && s_valid;
    bit pop = (mq.size() != 0) && s_ready;
    entry_t e;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.cls = classOf(s_instr);
      e.pc = s_pc;
      e.wd = s_wd;
      if (mq.size() < DEPTH) mq.push_back(e);
      else if (s_mode) begin
        void'(mq.pop_front());
        mq.push_back(e);
        if (!s_clr && movw < MAXC) movw++;
      end else if (!s_clr && mdrop < MAXC) mdrop++;
    end
    if (s_clr) begin
      for (int i = 0; i < 9; i++) mcnt[i] = 0;
      mdrop = 0;
      movw = 0;
    end else if (push && mcnt[classOf(s_instr)] < MAXC) begin
      mcnt[classOf(s_instr)]++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, then advances the model.
  task automatic applyStimulus(input logic s_en, s_mode, s_valid, input logic [31:0] s_pc,
                               s_instr, s_wd, input logic s_ready, s_clr);
    en = s_en; mode = s_mode; trace_valid = s_valid; trace_pc = s_pc;
    trace_instr = s_instr; trace_wd = s_wd; rd_ready = s_ready; clr_cnt = s_clr;
    @(posedge clk);
    #1;
    modelStep(s_en, s_mode, s_valid, s_pc, s_instr, s_wd, s_ready, s_clr);
    en = 0; trace_valid = 0; rd_ready = 0; clr_cnt = 0;
  endtask

  task automatic checkState();
    checkOutput("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("rd_class", 64'(rd_class), 64'(mq[0].cls));
      checkOutput("rd_pc", 64'(rd_pc), 64'(mq[0].pc));
      checkOutput("rd_wd", 64'(rd_wd), 64'(mq[0].wd));
    end
    checkOutput("level", 64'(level), 64'(mq.size()));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    checkOutput("ovw_cnt", 64'(ovw_cnt), 64'(movw));
    for (int i = 0; i < 10; i++) begin
      cnt_sel = 4'(i);
      #1;
      checkOutput($sformatf("cnt_val[%0d]", i), 64'(cnt_val), 64'((i <= 8) ? mcnt[i] : 0));
    end
  endtask

  task automatic checkCount(input string tag, input int sel, input int exp);
    cnt_sel = 4'(sel);
    #1;
    checkOutput(tag, 64'(cnt_val), 64'(exp));
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    $display("[TB] reset state");
    checkState();

    $display("[TB] single ADD push");
    applyStimulus(1, 0, 1, 32'h4, 32'h00221820, 32'd7, 0, 0);
    checkOutput("add_class", 64'(rd_class), 64'd1);
    checkOutput("add_pc", 64'(rd_pc), 64'h4);
    checkOutput("add_level", 64'(level), 64'd1);
    checkCount("add_count", 1, 1);
    checkState();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    $display("[TB] stop-when-full with 20 LW");
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 0, 1, 32'(i * 4), {6'd35, 26'($urandom)}, $urandom, 0, 0);
    checkOutput("stop_level", 64'(level), 64'd16);
    checkOutput("stop_drop", 64'(drop_cnt), 64'd4);
    checkCount("lw_count", 5, 20);
    checkState();
    for (int i = 0; i < 16; i++) begin
      checkOutput("stop_drain_pc", 64'(rd_pc), 64'(i * 4));
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    end
    checkState();

    $display("[TB] overwrite-oldest with 20 BEQ");
    for (int i = 0; i < 20; i++)
      applyStimulus(1, 1, 1, 32'(i * 4), {6'd4, 26'($urandom)}, $urandom, 0, 0);
    checkOutput("ovw_level", 64'(level), 64'd16);
    checkOutput("ovw_count", 64'(ovw_cnt), 64'd4);
    checkState();
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovw_drain_pc", 64'(rd_pc), 64'((i + 4) * 4));
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
    end

    $display("[TB] full FIFO with simultaneous push and pop");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++)
      applyStimulus(1, 0, 1, 32'h100 + 32'(i * 4), {6'd43, 26'($urandom)}, $urandom, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 1, 32'h200 + 32'(i * 4), {6'd43, 26'($urandom)}, $urandom, 1, 0);
      checkOutput("pp_level", 64'(level), 64'd16);
    end
    checkOutput("pp_drop", 64'(drop_cnt), 64'd0);
    checkState();
    for (int i = 0; i < 16; i++) begin
      checkState();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    end

    $display("[TB] OTHER classes and clear-with-push");
    applyStimulus(1, 0, 1, 32'h300, {6'd0, 20'($urandom), 6'd42}, 32'd1, 0, 0);
    applyStimulus(1, 0, 1, 32'h304, {6'd8, 26'($urandom)}, 32'd2, 0, 0);
    checkOutput("other_class", 64'(rd_class), 64'd0);
    checkCount("other_count", 0, 2);
    applyStimulus(1, 0, 1, 32'h308, 32'h00221820, 32'd3, 0, 1);
    checkOutput("clr_level", 64'(level), 64'd3);
    checkCount("clr_other", 0, 0);
    checkCount("clr_add", 1, 0);
    checkState();

    $display("[TB] reset during a burst");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 1, 32'h400 + 32'(i * 4), randInstr(), $urandom, 0, 0);
    checkOutput("burst_level", 64'(level), 64'd9);
    en = 1; trace_valid = 1; trace_instr = 32'h00221820;
    #4;
    rst = 1;
    #1;
    modelReset();
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_cnt", 64'(cnt_val), 64'd0);
    #3;
    rst = 0;
    en = 0; trace_valid = 0;
    applyStimulus(1, 0, 1, 32'h500, 32'h00221820, 32'd11, 0, 0);
    applyStimulus(1, 0, 1, 32'h504, 32'h00221822, 32'd12, 0, 0);
    checkOutput("resume_level", 64'(level), 64'd2);
    checkState();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                    $urandom, randInstr(), $urandom,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
      checkState();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable instruction-retire trace buffer for the MIPS-Lite pipelined CPU. Samples the writeback-stage instruction each cycle it is valid, classifies it (ADD/SUB/AND/OR/LW/SW/BEQ/J/other), and stores {class, PC, write data} in a parametrised FIFO. The FIFO can stop or overwrite when full, and per-class retire counters are kept alongside it. A host or bench drains entries over a valid/ready port, replacing per-cycle console tracing with on-chip capture.

## Interface
- PC_W, 32, PC width
- DATA_W, 32, register-file write-data width
- DEPTH, 16, FIFO entries; power of two, at least 2
- CNT_W, 16, width of every counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable; 0 ignores trace_valid
- mode  in  1  0 = stop-when-full, 1 = overwrite-oldest
- trace_valid  in  1  retiring instruction present this cycle
- trace_pc  in  PC_W  PC of retiring instruction
- trace_instr  in  32  instruction word
- trace_wd  in  DATA_W  register-file write data
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_class  out  4  head class code
- rd_pc  out  PC_W  head PC
- rd_wd  out  DATA_W  head write data
- level  out  $clog2(DEPTH)+1  entries held
- drop_cnt  out  CNT_W  pushes lost in stop mode; saturating
- ovw_cnt  out  CNT_W  entries overwritten in overwrite mode; saturating
- cnt_sel  in  4  class-counter select
- cnt_val  out  CNT_W  counter selected by cnt_sel; combinational; 0 for sel > 8
- clr_cnt  in  1  synchronous clear of all class counters, drop_cnt and ovw_cnt

## Operation
- Classification uses opcode = instr[31:26] and funct = instr[5:0].
  - opcode 0: funct 32 = ADD(1), 34 = SUB(2), 36 = AND(3), 37 = OR(4); any other funct = OTHER(0).
  - opcode 35 = LW(5), 43 = SW(6), 4 = BEQ(7), 2 = J(8); any other opcode = OTHER(0).
- push = en & trace_valid. pop = rd_valid & rd_ready.
- Each push increments the counter of its class by 1, saturating at 2^CNT_W−1. This happens whether or not the entry is stored.
- Not full: push writes the entry at wr_ptr. Pointers wrap modulo DEPTH.
- Full, push without pop:
  - mode 0: entry is discarded and drop_cnt increments.
  - mode 1: entry overwrites the oldest entry, rd_ptr advances, level stays DEPTH, and ovw_cnt increments.
- Full, push and pop together: both happen in either mode and level is unchanged. No drop and no overwrite are counted.
- Empty, pop: impossible, because rd_valid = 0. rd_ready is ignored.
- Empty, push and rd_ready together: push only. The new entry is not read in the same cycle.
- clr_cnt in the same cycle as a push: the clear wins, and every counter reads 0 next cycle. FIFO contents are unaffected.
- mode may change at any time and takes effect on the next push.

## Timing
- Reset values (asynchronous): wr_ptr = rd_ptr = 0, level = 0, rd_valid = 0, all counters 0. Entry storage is not reset. rd_class/rd_pc/rd_wd are don't-care while rd_valid = 0.
- Reset asserted mid-operation empties the FIFO and zeroes counters immediately. The first capture is on the first rising edge after rst deasserts.
- First-word-fall-through: an entry pushed at edge N gives rd_valid = 1 with its fields presented from edge N+1. rd_* are combinational from storage at rd_ptr.
- A pop at edge N presents the next entry from edge N+1.
- level, drop_cnt, ovw_cnt and class counters update on the same edge as the push/pop that changes them.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset, then push ADD (instr 0x00221820, pc 0x4, wd 7) with rd_ready = 0 → next cycle rd_valid = 1, rd_class = 1, rd_pc = 0x4, rd_wd = 7, level = 1; cnt_sel = 1 gives cnt_val = 1.
- DEPTH = 16, mode 0: push 20 LW (opcode 35), rd_ready = 0 → level = 16, drop_cnt = 4, LW counter = 20; draining returns the first 16 PCs in order.
- mode 1: push PCs 0..19 (step 4), then drain → level stays 16, ovw_cnt = 4, entries read are PC 16..76 in order.
- Full FIFO, push and pop every cycle for 10 cycles in mode 0 → level stays 16, drop_cnt = 0, output order preserved.
- R-type with funct 42 and opcode 8 → both class 0, OTHER counter = 2; clr_cnt together with a push → all counters 0 next cycle, level increments.
- Assert rst mid-burst with level = 9 → level = 0 and rd_valid = 0 immediately. Pushes resume normally after deassert.
